// File: rtl/time_set_pkg.sv
// Shared encodings for the front-panel time/date set controller.
// The state enum doubles as the field_sel code driven to the display.
package time_set_pkg;

    localparam logic [2:0] FIELD_RUN  = 3'd0;
    localparam logic [2:0] FIELD_HOUR = 3'd1;
    localparam logic [2:0] FIELD_MIN  = 3'd2;
    localparam logic [2:0] FIELD_CEN  = 3'd3;
    localparam logic [2:0] FIELD_YEAR = 3'd4;
    localparam logic [2:0] FIELD_MON  = 3'd5;
    localparam logic [2:0] FIELD_DAY  = 3'd6;

    // Bit positions inside the packed strobe vector.
    localparam int STB_HOUR = 0;
    localparam int STB_MIN  = 1;
    localparam int STB_CEN  = 2;
    localparam int STB_YEAR = 3;
    localparam int STB_MON  = 4;
    localparam int STB_DAY  = 5;
    localparam int STB_AMPM = 6;

    typedef enum logic [2:0] {
        ST_RUN  = FIELD_RUN,
        ST_HOUR = FIELD_HOUR,
        ST_MIN  = FIELD_MIN,
        ST_CEN  = FIELD_CEN,
        ST_YEAR = FIELD_YEAR,
        ST_MON  = FIELD_MON,
        ST_DAY  = FIELD_DAY
    } state_t;

    function automatic state_t next_field(input state_t s);
        case (s)
            ST_RUN:  return ST_HOUR;
            ST_HOUR: return ST_MIN;
            ST_MIN:  return ST_CEN;
            ST_CEN:  return ST_YEAR;
            ST_YEAR: return ST_MON;
            ST_MON:  return ST_DAY;
            default: return ST_RUN;
        endcase
    endfunction

    function automatic logic [6:0] field_strobe(input state_t s);
        logic [6:0] v;
        v = '0;
        case (s)
            ST_HOUR: v[STB_HOUR] = 1'b1;
            ST_MIN:  v[STB_MIN]  = 1'b1;
            ST_CEN:  v[STB_CEN]  = 1'b1;
            ST_YEAR: v[STB_YEAR] = 1'b1;
            ST_MON:  v[STB_MON]  = 1'b1;
            ST_DAY:  v[STB_DAY]  = 1'b1;
            default: v = '0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/time_set_controller_button_conditioner.sv
// Raw push-button -> synchronized, debounced level plus a one-cycle press pulse.
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic level,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync_meta;
    logic          sync_q;
    logic          level_q;
    logic [CW-1:0] stable_cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_meta  <= 1'b0;
            sync_q     <= 1'b0;
            level      <= 1'b0;
            level_q    <= 1'b0;
            press      <= 1'b0;
            stable_cnt <= '0;
        end else begin
            sync_meta <= btn_raw;
            sync_q    <= sync_meta;
            level_q   <= level;
            press     <= level & ~level_q;
            // Any sample that agrees with the current level restarts the qualification run.
            if (sync_q != level) begin
                if (stable_cnt >= CW'(DEBOUNCE_CYCLES - 1)) begin
                    level      <= sync_q;
                    stable_cnt <= '0;
                end else begin
                    stable_cnt <= stable_cnt + 1'b1;
                end
            end else begin
                stable_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/time_set_controller.sv
// Field-select FSM turning three front-panel buttons into clock/calendar adjust strobes,
// with auto-repeat on a held inc, idle timeout back to RUN and a display blink phase.
module time_set_controller
    import time_set_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES     = 1_000_000,
    parameter int REPEAT_DELAY_CYCLES = 50_000_000,
    parameter int REPEAT_RATE_CYCLES  = 10_000_000,
    parameter int TIMEOUT_TICKS       = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       one_Hz,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       btn_ampm,
    output logic       add_hour,
    output logic       add_minute,
    output logic       add_century,
    output logic       add_year,
    output logic       add_month,
    output logic       add_day,
    output logic       am_or_pm,
    output logic       set_active,
    output logic [2:0] field_sel,
    output logic       blink
);

    localparam int RPT_MAX = (REPEAT_DELAY_CYCLES > REPEAT_RATE_CYCLES) ?
                             REPEAT_DELAY_CYCLES : REPEAT_RATE_CYCLES;
    localparam int RW = $clog2(RPT_MAX + 1);
    localparam int IW = $clog2(TIMEOUT_TICKS + 1);

    logic mode_level, mode_press;
    logic inc_level,  inc_press;
    logic ampm_level, ampm_press;

    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode (
        .clk(clk), .reset(reset), .btn_raw(btn_mode), .level(mode_level), .press(mode_press));
    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_inc (
        .clk(clk), .reset(reset), .btn_raw(btn_inc), .level(inc_level), .press(inc_press));
    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ampm (
        .clk(clk), .reset(reset), .btn_raw(btn_ampm), .level(ampm_level), .press(ampm_press));

    logic unused_levels;
    assign unused_levels = mode_level ^ ampm_level;

    state_t        state, state_next;
    logic [6:0]    strobe_q, strobe_next;
    logic [RW-1:0] rpt_cnt, rpt_limit;
    logic          rpt_armed, rpt_fast, rpt_fire;
    logic [IW-1:0] idle_cnt;
    logic          in_set, any_press, timeout;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        state_next  = state;
        strobe_next = '0;
        in_set      = (state != ST_RUN);
        any_press   = mode_press | inc_press | ampm_press;
        rpt_limit   = rpt_fast ? RW'(REPEAT_RATE_CYCLES - 1) : RW'(REPEAT_DELAY_CYCLES - 1);
        rpt_fire    = in_set && rpt_armed && inc_level && (rpt_cnt == rpt_limit);
        timeout     = in_set && !any_press && !inc_level && one_Hz &&
                      (idle_cnt >= IW'(TIMEOUT_TICKS - 1));

        // Priority mode > inc (press or repeat) > ampm; losers are dropped, never queued.
        if (mode_press) begin
            state_next = next_field(state);
        end else if (in_set && inc_press) begin
            strobe_next = field_strobe(state);
        end else if (rpt_fire) begin
            strobe_next = field_strobe(state);
        end else if (ampm_press && state == ST_HOUR) begin
            strobe_next[STB_AMPM] = 1'b1;
        end else if (timeout) begin
            state_next = ST_RUN;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_RUN;
            strobe_q   <= '0;
            set_active <= 1'b0;
            blink      <= 1'b1;
            rpt_cnt    <= '0;
            rpt_armed  <= 1'b0;
            rpt_fast   <= 1'b0;
            idle_cnt   <= '0;
        end else begin
            state      <= state_next;
            strobe_q   <= strobe_next;
            set_active <= (state_next != ST_RUN);

            // Repeat only ever follows a real inc strobe within the same hold.
            if (!in_set || !inc_level || mode_press) begin
                rpt_cnt   <= '0;
                rpt_armed <= 1'b0;
                rpt_fast  <= 1'b0;
            end else if (inc_press) begin
                rpt_cnt   <= '0;
                rpt_armed <= 1'b1;
                rpt_fast  <= 1'b0;
            end else if (rpt_fire) begin
                rpt_cnt  <= '0;
                rpt_fast <= 1'b1;
            end else if (rpt_armed && rpt_cnt != RW'(RPT_MAX)) begin
                rpt_cnt <= rpt_cnt + 1'b1;
            end

            if (!in_set || any_press || inc_level || timeout) begin
                idle_cnt <= '0;
            end else if (one_Hz && idle_cnt != IW'(TIMEOUT_TICKS)) begin
                idle_cnt <= idle_cnt + 1'b1;
            end

            // Keep the field visible when leaving set mode, on a field change and while inc is held.
            if (state_next == ST_RUN || state_next != state || inc_level) begin
                blink <= 1'b1;
            end else if (one_Hz) begin
                blink <= ~blink;
            end
        end
    end

    assign field_sel   = state;
    assign add_hour    = strobe_q[STB_HOUR];
    assign add_minute  = strobe_q[STB_MIN];
    assign add_century = strobe_q[STB_CEN];
    assign add_year    = strobe_q[STB_YEAR];
    assign add_month   = strobe_q[STB_MON];
    assign add_day     = strobe_q[STB_DAY];
    assign am_or_pm    = strobe_q[STB_AMPM];

endmodule

// File: tb/tb_time_set_controller.sv
// Scenario bench for time_set_controller: expected strobes are queued with their cycle
// numbers when buttons are driven and matched against the DUT as strobes appear.
module tb_time_set_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic       one_Hz;
    logic       btn_mode, btn_inc, btn_ampm;
    logic       add_hour, add_minute, add_century, add_year, add_month, add_day, am_or_pm;
    logic       set_active;
    logic [2:0] field_sel;
    logic       blink;

    time_set_controller #(
        .DEBOUNCE_CYCLES(4), .REPEAT_DELAY_CYCLES(20),
        .REPEAT_RATE_CYCLES(5), .TIMEOUT_TICKS(3)
    ) dut (
        .clk(clk), .reset(reset), .one_Hz(one_Hz),
        .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_ampm(btn_ampm),
        .add_hour(add_hour), .add_minute(add_minute), .add_century(add_century),
        .add_year(add_year), .add_month(add_month), .add_day(add_day),
        .am_or_pm(am_or_pm), .set_active(set_active), .field_sel(field_sel), .blink(blink)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int idx;
        int at;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Strobe indices: 0 hour, 1 minute, 2 century, 3 year, 4 month, 5 day, 6 am/pm.
    task automatic push_exp(input int idx, input int at);
        exp_t e;
        e.idx = idx;
        e.at  = at;
        sb.push_back(e);
    endtask

    task automatic monitor_loop();
        logic [6:0] v;
        int         idx;
        exp_t       e;
        forever begin
            @(negedge clk);
            v = {am_or_pm, add_day, add_month, add_year, add_century, add_minute, add_hour};
            if (v != 7'd0) begin
                idx = 0;
                for (int i = 0; i < 7; i++) if (v[i]) idx = i;
                checks++;
                if ($countones(v) != 1) begin
                    errors++;
                    $display("FAIL strobe_onehot cycle %0d got %b want a single strobe", cyc, v);
                end else if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_strobe cycle %0d got idx %0d want none", cyc, idx);
                end else begin
                    e = sb.pop_front();
                    if (e.idx != idx || e.at != cyc) begin
                        errors++;
                        $display("FAIL strobe_match got idx %0d at %0d want idx %0d at %0d",
                                 idx, cyc, e.idx, e.at);
                    end
                end
            end
        end
    endtask

    task automatic one_hz_loop();
        forever begin
            @(negedge clk);
            one_Hz = (cyc % 50 == 0);
        end
    endtask

    task automatic drive_btn(input int which, input logic val);
        case (which)
            0:       btn_mode = val;
            1:       btn_inc  = val;
            default: btn_ampm = val;
        endcase
    endtask

    // Press for 10 cycles, release, then let the release debounce out.
    task automatic tap(input int which, output int t0);
        @(negedge clk);
        drive_btn(which, 1'b1);
        t0 = cyc;
        repeat (10) @(negedge clk);
        drive_btn(which, 1'b0);
        repeat (12) @(negedge clk);
    endtask

    task automatic tap_mode(input int want_field);
        int t0;
        tap(0, t0);
        checks++;
        if (field_sel !== 3'(want_field) || set_active !== (want_field != 0)) begin
            errors++;
            $display("FAIL mode_step got field %0d active %b want field %0d", field_sel,
                     set_active, want_field);
        end
    endtask

    task automatic check_sb_empty(input string name);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s missing strobes got %0d pending want 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic check_reset_outputs(input string name);
        logic [11:0] got;
        got = {add_hour, add_minute, add_century, add_year, add_month, add_day, am_or_pm,
               set_active, field_sel, blink};
        checks++;
        if (got !== 12'b0000_0000_0001) begin
            errors++;
            $display("FAIL %s outputs got %b want 000000000001", name, got);
        end
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        btn_ampm = 1'b0;
        one_Hz   = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset_state");
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_first_press();
        int t0;
        @(negedge clk);
        btn_mode = 1'b1;
        t0 = cyc;
        repeat (7) @(negedge clk);
        checks++;
        if (field_sel !== 3'd0 || set_active !== 1'b0) begin
            errors++;
            $display("FAIL first_press_early got field %0d active %b want 0 0", field_sel, set_active);
        end
        @(negedge clk);
        checks++;
        if (cyc != t0 + 8 || field_sel !== 3'd1 || set_active !== 1'b1 || blink !== 1'b1) begin
            errors++;
            $display("FAIL first_press_latency got field %0d active %b blink %b want 1 1 1",
                     field_sel, set_active, blink);
        end
        btn_mode = 1'b0;
        repeat (12) @(negedge clk);
        check_sb_empty("first_press_no_strobe");
    endtask

    task automatic test_field_walk();
        int t0;
        tap_mode(2);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            btn_inc = 1'b1;
            t0 = cyc;
            push_exp(1, t0 + 8);
            repeat (10) @(negedge clk);
            btn_inc = 1'b0;
            repeat (12) @(negedge clk);
        end
        check_sb_empty("field_walk_minutes");
        tap_mode(3);
        tap_mode(4);
        tap_mode(5);
        tap_mode(6);
        tap_mode(0);
    endtask

    task automatic test_auto_repeat();
        int t0;
        for (int f = 1; f <= 6; f++) tap_mode(f);
        @(negedge clk);
        btn_inc = 1'b1;
        t0 = cyc;
        // First strobe at press pulse + 1; level drops at release + 6, last repeat can fire on that edge.
        push_exp(5, t0 + 8);
        for (int t = t0 + 28; t <= t0 + 66; t += 5) push_exp(5, t);
        repeat (30) @(negedge clk);
        checks++;
        if (blink !== 1'b1) begin
            errors++;
            $display("FAIL blink_while_held got %b want 1", blink);
        end
        repeat (30) @(negedge clk);
        btn_inc = 1'b0;
        repeat (40) @(negedge clk);
        check_sb_empty("auto_repeat_day");
        tap_mode(0);
    endtask

    task automatic test_bounce_ampm();
        int t0;
        tap_mode(1);
        for (int i = 0; i < 10; i++) begin
            btn_inc = ~btn_inc;
            repeat (2) @(negedge clk);
        end
        btn_inc = 1'b0;
        repeat (12) @(negedge clk);
        check_sb_empty("bounce_no_hour");
        @(negedge clk);
        btn_ampm = 1'b1;
        t0 = cyc;
        push_exp(6, t0 + 8);
        repeat (10) @(negedge clk);
        btn_ampm = 1'b0;
        repeat (12) @(negedge clk);
        check_sb_empty("ampm_in_hour");
        tap_mode(2);
        tap_mode(3);
        tap_mode(4);
        tap(2, t0);
        check_sb_empty("ampm_in_year_ignored");
        tap_mode(5);
        tap_mode(6);
        tap_mode(0);
    endtask

    task automatic test_collision_timeout();
        int t0;
        tap_mode(1);
        @(negedge clk);
        btn_mode = 1'b1;
        btn_inc  = 1'b1;
        t0 = cyc;
        repeat (8) @(negedge clk);
        checks++;
        if (field_sel !== 3'd2) begin
            errors++;
            $display("FAIL collision_state got field %0d want 2", field_sel);
        end
        repeat (2) @(negedge clk);
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        repeat (220) @(negedge clk);
        check_sb_empty("collision_no_strobe");
        checks++;
        if (field_sel !== 3'd0 || set_active !== 1'b0 || blink !== 1'b1) begin
            errors++;
            $display("FAIL idle_timeout got field %0d active %b blink %b want 0 0 1",
                     field_sel, set_active, blink);
        end
    endtask

    task automatic test_reset_mid_repeat();
        int t0;
        tap_mode(1);
        tap_mode(2);
        tap_mode(3);
        @(negedge clk);
        btn_inc = 1'b1;
        t0 = cyc;
        push_exp(2, t0 + 8);
        push_exp(2, t0 + 28);
        push_exp(2, t0 + 33);
        push_exp(2, t0 + 38);
        repeat (40) @(negedge clk);
        reset = 1'b1;
        #1;
        check_reset_outputs("reset_mid_repeat");
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        checks++;
        if (field_sel !== 3'd0 || set_active !== 1'b0) begin
            errors++;
            $display("FAIL held_after_reset got field %0d active %b want 0 0", field_sel, set_active);
        end
        btn_inc = 1'b0;
        repeat (12) @(negedge clk);
        check_sb_empty("reset_mid_repeat_century");
    endtask

    initial begin
        test_reset();
        fork
            monitor_loop();
            one_hz_loop();
        join_none
        test_first_press();
        test_field_walk();
        test_auto_repeat();
        test_bounce_ampm();
        test_collision_timeout();
        test_reset_mid_repeat();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
